cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 tb/tb_cdb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs arbitrated round-robin onto N_CDB registered broadcast slots
module cdb_arbiter #(
   parameter int N_SRC  = 4,
   parameter int N_CDB  = 2,
   parameter int DEPTH  = 2,
   parameter int PREG_W = 6,
   parameter int ROB_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [N_SRC-1:0]  src_valid,
   output logic [N_SRC-1:0]  src_ready,
   input  logic [PREG_W-1:0] src_rd     [N_SRC],
   input  logic [31:0]       src_value  [N_SRC],
   input  logic [ROB_W-1:0]  src_rob_id [N_SRC],
   output logic [N_CDB-1:0]  cdb_valid,
   output logic [PREG_W-1:0] cdb_rd     [N_CDB],
   output logic [31:0]       cdb_value  [N_CDB],
   output logic [ROB_W-1:0]  cdb_rob_id [N_CDB]
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = N_SRC > 1 ? $clog2(N_SRC) : 1;
   localparam int NW = N_CDB > 1 ? $clog2(N_CDB) : 1;

   logic [CW-1:0]     cnt_q [N_SRC], cnt_d [N_SRC];
   logic [PW-1:0]     wp_q [N_SRC], wp_d [N_SRC], rp_q [N_SRC], rp_d [N_SRC];
   logic [SW-1:0]     rr_q, rr_d;
   logic [N_CDB-1:0]  cv_q, cv_d;
   logic [PREG_W-1:0] crd_q [N_CDB], crd_d [N_CDB];
   logic [31:0]       cval_q [N_CDB], cval_d [N_CDB];
   logic [ROB_W-1:0]  crob_q [N_CDB], crob_d [N_CDB];
   logic [PREG_W-1:0] rd_mem [N_SRC][DEPTH];
   logic [31:0]       val_mem [N_SRC][DEPTH];
   logic [ROB_W-1:0]  rob_mem [N_SRC][DEPTH];
   logic [N_SRC-1:0]  enq, deq;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign cdb_valid  = cv_q;
   assign cdb_rd     = crd_q;
   assign cdb_value  = cval_q;
   assign cdb_rob_id = crob_q;

   // ready comes purely from the registered occupancy, never from this cycle's dequeue
   always_comb begin
      src_ready = '0;
      for (int i = 0; i < N_SRC; i++) src_ready[i] = cnt_q[i] < CW'(DEPTH);
   end

   // scan from rr_q, granting up to N_CDB non-empty heads into consecutive slots
   always_comb begin
      int n;
      logic [SW-1:0] idx;
      n      = 0;
      idx    = '0;
      deq    = '0;
      cv_d   = '0;
      crd_d  = crd_q;
      cval_d = cval_q;
      crob_d = crob_q;
      rr_d   = rr_q;
      for (int k = 0; k < N_SRC; k++) begin
         idx = SW'((int'(rr_q) + k) % N_SRC);
         if (cnt_q[idx] != '0 && n < N_CDB) begin
            deq[idx]          = 1'b1;
            cv_d[NW'(n)]      = 1'b1;
            crd_d[NW'(n)]     = rd_mem[idx][rp_q[idx]];
            cval_d[NW'(n)]    = val_mem[idx][rp_q[idx]];
            crob_d[NW'(n)]    = rob_mem[idx][rp_q[idx]];
            rr_d              = (idx == SW'(N_SRC - 1)) ? '0 : idx + 1'b1;
            n                 = n + 1;
         end
      end
      if (flush) begin
         deq    = '0;
         cv_d   = '0;
         crd_d  = crd_q;
         cval_d = cval_q;
         crob_d = crob_q;
         rr_d   = rr_q;
      end
   end

   // per-source FIFO bookkeeping; enqueue and dequeue may coincide, flush clears everything
   always_comb begin
      enq = '0;
      for (int i = 0; i < N_SRC; i++) begin
         enq[i]   = src_valid[i] && src_ready[i] && !flush;
         wp_d[i]  = flush ? '0 : enq[i] ? inc(wp_q[i]) : wp_q[i];
         rp_d[i]  = flush ? '0 : deq[i] ? inc(rp_q[i]) : rp_q[i];
         cnt_d[i] = flush ? '0 : cnt_q[i] + CW'(enq[i]) - CW'(deq[i]);
      end
   end

   // control state and broadcast registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SRC; i++) begin
            cnt_q[i] <= '0;
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
         end
         for (int k = 0; k < N_CDB; k++) begin
            crd_q[k]  <= '0;
            cval_q[k] <= '0;
            crob_q[k] <= '0;
         end
         rr_q <= '0;
         cv_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         rr_q   <= rr_d;
         cv_q   <= cv_d;
         crd_q  <= crd_d;
         cval_q <= cval_d;
         crob_q <= crob_d;
      end
   end

   // result storage; contents are meaningless once counts are cleared
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_SRC; i++) begin
         if (enq[i]) begin
            rd_mem[i][wp_q[i]]  <= src_rd[i];
            val_mem[i][wp_q[i]] <= src_value[i];
            rob_mem[i][wp_q[i]] <= src_rob_id[i];
         end
      end
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: two-slot and one-slot arbiters checked against a queue-based reference model
module tb_cdb_arbiter;
   localparam int NS = 4;
   localparam int D  = 2;

   logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
   logic [3:0]  sv = '0;
   logic [5:0]  srd [NS];
   logic [31:0] sval [NS];
   logic [2:0]  srob [NS];
   logic [3:0]  rdy0, rdy1;
   logic [1:0]  cv0;
   logic [5:0]  crd0 [2];
   logic [31:0] cval0 [2];
   logic [2:0]  crob0 [2];
   logic [0:0]  cv1;
   logic [5:0]  crd1 [1];
   logic [31:0] cval1 [1];
   logic [2:0]  crob1 [1];

   int checks = 0, errors = 0, bc1 = 0;
   logic [40:0] mq [2][NS][$];
   int          rr [2];
   logic [1:0]  ev [2];
   logic [40:0] ep [2][2];

   cdb_arbiter u0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(sv), .src_ready(rdy0),
      .src_rd(srd), .src_value(sval), .src_rob_id(srob),
      .cdb_valid(cv0), .cdb_rd(crd0), .cdb_value(cval0), .cdb_rob_id(crob0)
   );

   cdb_arbiter #(.N_CDB(1)) u1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .src_valid(sv), .src_ready(rdy1),
      .src_rd(srd), .src_value(sval), .src_rob_id(srob),
      .cdb_valid(cv1), .cdb_rd(crd1), .cdb_value(cval1), .cdb_rob_id(crob1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_rdy(input int m);
      logic [3:0] r;
      for (int s = 0; s < NS; s++) r[s] = mq[m][s].size() < D;
      return r;
   endfunction

   task automatic model();
      logic [3:0] acc;
      int nc, n, last, s;
      for (int m = 0; m < 2; m++) begin
         nc = (m == 0) ? 2 : 1;
         n = 0;
         last = -1;
         ev[m] = '0;
         for (int j = 0; j < NS; j++) acc[j] = sv[j] && mq[m][j].size() < D;
         if (flush) begin
            for (int j = 0; j < NS; j++) mq[m][j].delete();
         end else begin
            for (int k = 0; k < NS; k++) begin
               s = (rr[m] + k) % NS;
               if (mq[m][s].size() != 0 && n < nc) begin
                  ep[m][n] = mq[m][s].pop_front();
                  ev[m][n] = 1'b1;
                  n++;
                  last = s;
               end
            end
            if (last >= 0) rr[m] = (last + 1) % NS;
            for (int j = 0; j < NS; j++) if (acc[j]) mq[m][j].push_back({srd[j], sval[j], srob[j]});
         end
      end
   endtask

   task automatic compare();
      chk("valid0", 64'(cv0), 64'(ev[0]));
      chk("valid1", 64'(cv1), 64'(ev[1]));
      for (int k = 0; k < 2; k++) if (ev[0][k]) chk("payload0", 64'({crd0[k], cval0[k], crob0[k]}), 64'(ep[0][k]));
      if (ev[1][0]) chk("payload1", 64'({crd1[0], cval1[0], crob1[0]}), 64'(ep[1][0]));
      chk("ready0", 64'(rdy0), 64'(exp_rdy(0)));
      chk("ready1", 64'(rdy1), 64'(exp_rdy(1)));
      bc1 += int'(cv1);
   endtask

   task automatic step();
      model();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic rand_pay();
      for (int s = 0; s < NS; s++) begin
         srd[s]  = 6'($urandom);
         sval[s] = $urandom;
         srob[s] = 3'($urandom);
      end
   endtask

   task automatic do_reset();
      sv = '0;
      flush = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_valid0", 64'(cv0), 64'(0));
      chk("rst_valid1", 64'(cv1), 64'(0));
      chk("rst_ready0", 64'(rdy0), 64'(4'hf));
      chk("rst_ready1", 64'(rdy1), 64'(4'hf));
      chk("rst_payload0", 64'({crd0[0], cval0[0], crob0[0], crd0[1], cval0[1], crob0[1]}), 64'(0));
      chk("rst_payload1", 64'({crd1[0], cval1[0], crob1[0]}), 64'(0));
      for (int m = 0; m < 2; m++) begin
         rr[m] = 0;
         for (int s = 0; s < NS; s++) mq[m][s].delete();
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int s = 0; s < NS; s++) begin
         srd[s] = '0;
         sval[s] = '0;
         srob[s] = '0;
      end
      #2;
      do_reset();
      step();
      sv = 4'b0100;
      srd[2] = 6'd5;
      sval[2] = 32'hDEADBEEF;
      srob[2] = 3'd3;
      step();
      sv = '0;
      step();
      chk("single_valid", 64'(cv0), 64'(2'b01));
      chk("single_rd", 64'(crd0[0]), 64'(5));
      chk("single_value", 64'(cval0[0]), 64'(32'hDEADBEEF));
      chk("single_rob", 64'(crob0[0]), 64'(3));
      do_reset();
      sv = 4'hf;
      for (int c = 0; c < 6; c++) begin
         rand_pay();
         for (int s = 0; s < NS; s++) srob[s] = 3'(s);
         step();
         if (c == 1 || c == 3) begin
            chk("contend_slot0", 64'(crob0[0]), 64'(0));
            chk("contend_slot1", 64'(crob0[1]), 64'(1));
         end
         if (c == 2) begin
            chk("contend_slot0", 64'(crob0[0]), 64'(2));
            chk("contend_slot1", 64'(crob0[1]), 64'(3));
         end
      end
      sv = '0;
      repeat (6) step();
      do_reset();
      bc1 = 0;
      sv = 4'hf;
      rand_pay();
      step();
      rand_pay();
      step();
      chk("bp_ready1", 64'(rdy1), 64'(4'b0001));
      sv = '0;
      repeat (12) step();
      chk("bp_count", 64'(bc1), 64'(8));
      sv = 4'b0111;
      rand_pay();
      step();
      sv = '0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_valid0", 64'(cv0), 64'(0));
      chk("flush_ready0", 64'(rdy0), 64'(4'hf));
      chk("flush_ready1", 64'(rdy1), 64'(4'hf));
      sv = 4'b1000;
      rand_pay();
      step();
      sv = '0;
      step();
      chk("flush_after", 64'(cv0), 64'(2'b01));
      sv = 4'hf;
      rand_pay();
      step();
      sv = '0;
      step();
      #3;
      do_reset();
      repeat (3) step();
      sv = 4'b0010;
      for (int c = 0; c < 8; c++) begin
         rand_pay();
         step();
      end
      sv = '0;
      repeat (3) step();
      repeat (400) begin
         sv = 4'($urandom);
         rand_pay();
         flush = ($urandom_range(0, 31) == 0);
         step();
      end
      flush = 1'b0;
      sv = '0;
      repeat (6) step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
